// File: rtl/sc_io_debounce.sv
// sc_io_debounce: 2-flop sync + per-bit debounce for KEY/SW, sticky key flags (release flags with SC_IO_KEY_RELEASE_EN)
module sc_io_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] key_raw,
  input  logic [9:0] sw_raw,
  output logic [3:0] key_level,
  output logic [9:0] sw_level,
  output logic [3:0] key_press,
  input  logic       clr_press,
  input  logic [3:0] clr_mask
`ifdef SC_IO_KEY_RELEASE_EN
  ,
  output logic [3:0] key_release
`endif
);
  localparam int N = 14;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [N-1:0] s1_q, s2_q, lvl_q, lvl_d;
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];
  logic [3:0] press_q, press_d, clr, rise;
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = cnt_q;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = (s2_q[i] == lvl_q[i] || cnt_q[i] == LAST) ? '0 : cnt_q[i] + CNT_W'(1);
      lvl_d[i] = (s2_q[i] != lvl_q[i] && cnt_q[i] == LAST) ? s2_q[i] : lvl_q[i];
    end
  end
  assign clr = clr_press ? clr_mask : 4'b0;
  assign rise = lvl_d[3:0] & ~lvl_q[3:0];
  // set wins over a simultaneous clear so no event is lost
  assign press_d = (press_q & ~clr) | rise;
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
      lvl_q <= '0;
      press_q <= '0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      s1_q <= {sw_raw, ~key_raw};
      s2_q <= s1_q;
      lvl_q <= lvl_d;
      press_q <= press_d;
      cnt_q <= cnt_d;
    end
  end
  assign key_level = lvl_q[3:0];
  assign sw_level = lvl_q[13:4];
  assign key_press = press_q;
`ifdef SC_IO_KEY_RELEASE_EN
  logic [3:0] rel_q, rel_d;
  assign rel_d = (rel_q & ~clr) | (lvl_q[3:0] & ~lvl_d[3:0]);
  always_ff @(posedge clock) begin
    if (reset) rel_q <= '0;
    else rel_q <= rel_d;
  end
  assign key_release = rel_q;
`endif
endmodule

// File: tb/tb_sc_io_debounce.sv
// tb_sc_io_debounce: directed checks of sc_io_debounce with DEBOUNCE_CYCLES=4
module tb_sc_io_debounce;
  logic       clock = 0;
  logic       reset;
  logic [3:0] key_raw;
  logic [9:0] sw_raw;
  logic [3:0] key_level, key_press, clr_mask;
  logic [9:0] sw_level;
  logic       clr_press;
  int tests = 0;
  int fails = 0;
`ifdef SC_IO_KEY_RELEASE_EN
  logic [3:0] key_release;
`endif

  sc_io_debounce #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .key_raw(key_raw), .sw_raw(sw_raw),
    .key_level(key_level), .sw_level(sw_level), .key_press(key_press),
    .clr_press(clr_press), .clr_mask(clr_mask)
`ifdef SC_IO_KEY_RELEASE_EN
    , .key_release(key_release)
`endif
  );

  always #5 clock = ~clock;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_rel(input string tag, input logic [3:0] exp);
`ifdef SC_IO_KEY_RELEASE_EN
    chk(tag, {12'b0, key_release}, {12'b0, exp});
`endif
  endtask

  initial begin
    reset = 1; key_raw = 4'hF; sw_raw = '0; clr_press = 0; clr_mask = '0;
    step(3);
    chk("rst_key_level", {12'b0, key_level}, 16'h0);
    chk("rst_sw_level", {6'b0, sw_level}, 16'h0);
    chk("rst_key_press", {12'b0, key_press}, 16'h0);
    chk_rel("rst_key_release", 4'h0);
    reset = 0;
    step(4);
    chk("idle_key_level", {12'b0, key_level}, 16'h0);
    // clean press on key 0
    key_raw[0] = 0;
    step(5);
    chk("press0_early", {12'b0, key_level}, 16'h0);
    step(1);
    chk("press0_level", {12'b0, key_level}, 16'h1);
    chk("press0_flag", {12'b0, key_press}, 16'h1);
    chk("press0_sw", {6'b0, sw_level}, 16'h0);
    // bounce on key 1
    key_raw[1] = 0;
    step(3);
    key_raw[1] = 1;
    step(1);
    key_raw[1] = 0;
    step(3);
    chk("bounce_glitch", {12'b0, key_level}, 16'h1);
    step(2);
    chk("bounce_early", {12'b0, key_level}, 16'h1);
    chk("bounce_early_flag", {12'b0, key_press}, 16'h1);
    step(1);
    chk("bounce_level", {12'b0, key_level}, 16'h3);
    chk("bounce_flag", {12'b0, key_press}, 16'h3);
    // masked clear and empty-mask clear
    clr_press = 1; clr_mask = 4'b0001;
    step(1);
    clr_press = 0;
    chk("clear_bit0", {12'b0, key_press}, 16'h2);
    clr_press = 1; clr_mask = 4'b0000;
    step(1);
    clr_press = 0;
    chk("clear_mask0", {12'b0, key_press}, 16'h2);
    // set/clear collision on key 2
    key_raw[2] = 0;
    step(5);
    chk("coll_early", {12'b0, key_press}, 16'h2);
    clr_press = 1; clr_mask = 4'b0100;
    step(1);
    clr_press = 0;
    chk("coll_level", {12'b0, key_level}, 16'h7);
    chk("coll_flag", {12'b0, key_press}, 16'h6);
    // release keys 0..2, flags persist
    key_raw = 4'hF;
    step(5);
    chk("rel_early", {12'b0, key_level}, 16'h7);
    chk_rel("rel_flag_early", 4'h0);
    step(1);
    chk("rel_level", {12'b0, key_level}, 16'h0);
    chk("rel_press_kept", {12'b0, key_press}, 16'h6);
    chk_rel("rel_flag", 4'h7);
    clr_press = 1; clr_mask = 4'hF;
    step(1);
    clr_press = 0;
    chk("clear_all", {12'b0, key_press}, 16'h0);
    chk_rel("clear_all_rel", 4'h0);
    // reset mid-count on key 3
    key_raw[3] = 0;
    step(3);
    reset = 1; key_raw = 4'hF;
    step(2);
    chk("midrst_level", {12'b0, key_level}, 16'h0);
    reset = 0;
    step(8);
    chk("midrst_after_level", {12'b0, key_level}, 16'h0);
    chk("midrst_after_flag", {12'b0, key_press}, 16'h0);
    // reset with switches up
    reset = 1; sw_raw = 10'h3FF;
    step(3);
    chk("swrst_sw", {6'b0, sw_level}, 16'h0);
    chk("swrst_press", {12'b0, key_press}, 16'h0);
    reset = 0;
    step(5);
    chk("swrst_early", {6'b0, sw_level}, 16'h0);
    step(1);
    chk("swrst_level", {6'b0, sw_level}, 16'h3FF);
    chk("swrst_press_after", {12'b0, key_press}, 16'h0);
    // single switch drop
    sw_raw[5] = 0;
    step(6);
    chk("sw5_low", {6'b0, sw_level}, 16'h3DF);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
